// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the result bus arbiter
package alu_pkg;

    localparam int REQ_N      = 8;   // number of requesters sharing the result bus
    localparam int SEL_W      = 3;   // width of a requester index
    localparam int PRIO_RR    = 0;   // round-robin arbitration
    localparam int PRIO_FIXED = 1;   // fixed priority, lowest index wins

    // Output stage occupancy; the state bit doubles as out_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

endpackage

// File: rtl/mux_8to1.sv
// rtl/mux_8to1.sv - 8:1 data multiplexer for the result bus
// Ports:
//   sel     in   3      index of the input routed to y
//   d0..d7  in   WIDTH  candidate words
//   y       out  WIDTH  selected word
module Mux_8to1 #(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            3'd0: y = d0;
            3'd1: y = d1;
            3'd2: y = d2;
            3'd3: y = d3;
            3'd4: y = d4;
            3'd5: y = d5;
            3'd6: y = d6;
            3'd7: y = d7;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/result_bus_arbiter.sv
// rtl/result_bus_arbiter.sv - 8-way arbiter driving a registered result bus stage
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   req[7:0]    per-requester word-valid; word held stable until acked
//   in0..in7    candidate words
//   ack[7:0]    one-hot, combinational; marks the word captured at the next edge
//   out_data    registered winning word
//   out_src     index of the requester that supplied out_data
//   out_valid   out_data/out_src valid
//   out_ready   consumer accepts the word when out_valid & out_ready
module result_bus_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int PRIORITY_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    output logic [7:0]       ack,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_src,
    output logic             out_valid,
    input  logic             out_ready
);

    stage_state_e     state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] base;
    logic [WIDTH-1:0] mux_y;
    logic             any_req;
    logic             load_en;

    // Rotate req so that index 'p' sits at bit 0, take the lowest set bit,
    // then add 'p' back (mod 8) to recover the original requester index.
    function automatic logic [SEL_W-1:0] pick_winner(input logic [REQ_N-1:0] r,
                                                     input logic [SEL_W-1:0] p);
        logic [2*REQ_N-1:0] dbl;
        logic [REQ_N-1:0]   rot;
        logic [SEL_W-1:0]   idx;
        dbl = {r, r};
        rot = dbl[p +: REQ_N];
        idx = '0;
        for (int k = REQ_N - 1; k >= 0; k--) begin
            if (rot[k]) idx = k[SEL_W-1:0];
        end
        return idx + p;
    endfunction

    // Fixed priority is the same search anchored permanently at index 0.
    assign base      = (PRIORITY_MODE == PRIO_RR) ? ptr : '0;
    assign sel       = pick_winner(req, base);
    assign any_req   = |req;
    assign out_valid = (state == ST_FULL);
    assign load_en   = !out_valid || out_ready;

    always_comb begin
        ack = '0;
        if (load_en && any_req && !rst) ack[sel] = 1'b1;
    end

    Mux_8to1 #(.WIDTH(WIDTH)) u_mux (
        .sel (sel),
        .d0  (in0),
        .d1  (in1),
        .d2  (in2),
        .d3  (in3),
        .d4  (in4),
        .d5  (in5),
        .d6  (in6),
        .d7  (in7),
        .y   (mux_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_src  <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (any_req) begin
                        out_data <= mux_y;
                        out_src  <= sel;
                        ptr      <= sel + 1'b1;
                        state    <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // Drain and refill share one edge so the stream has no bubble.
                    if (out_ready) begin
                        if (any_req) begin
                            out_data <= mux_y;
                            out_src  <= sel;
                            ptr      <= sel + 1'b1;
                        end else begin
                            state <= ST_EMPTY;
                        end
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// tb/tb_result_bus_arbiter.sv - scoreboard bench for result_bus_arbiter
module tb_result_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req, req_fx;
    logic       rdy, rdy_fx;
    logic [7:0] in_w [8];

    logic [7:0] ack, ack_fx;
    logic [7:0] data, data_fx;
    logic [2:0] src, src_fx;
    logic       vld, vld_fx;

    logic [10:0] q_rr [$];
    logic [10:0] q_fx [$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 8; i++) in_w[i] = 8'h01 << i;
    end

    result_bus_arbiter #(.WIDTH(8), .PRIORITY_MODE(0)) u_rr (
        .clk(clk), .rst(rst), .req(req),
        .in0(in_w[0]), .in1(in_w[1]), .in2(in_w[2]), .in3(in_w[3]),
        .in4(in_w[4]), .in5(in_w[5]), .in6(in_w[6]), .in7(in_w[7]),
        .ack(ack), .out_data(data), .out_src(src), .out_valid(vld), .out_ready(rdy)
    );

    result_bus_arbiter #(.WIDTH(8), .PRIORITY_MODE(1)) u_fx (
        .clk(clk), .rst(rst), .req(req_fx),
        .in0(in_w[0]), .in1(in_w[1]), .in2(in_w[2]), .in3(in_w[3]),
        .in4(in_w[4]), .in5(in_w[5]), .in6(in_w[6]), .in7(in_w[7]),
        .ack(ack_fx), .out_data(data_fx), .out_src(src_fx), .out_valid(vld_fx), .out_ready(rdy_fx)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor_rr();
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (!rst && vld && rdy) begin
                if (q_rr.size() == 0) begin
                    check("rr_unexpected_word", {21'd0, data, src}, 32'hFFFF);
                end else begin
                    e = q_rr.pop_front();
                    check("rr_out_data", {24'd0, data}, {24'd0, e[10:3]});
                    check("rr_out_src", {29'd0, src}, {29'd0, e[2:0]});
                end
            end
        end
    endtask

    task automatic monitor_fx();
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (!rst && vld_fx && rdy_fx) begin
                if (q_fx.size() == 0) begin
                    check("fx_unexpected_word", {21'd0, data_fx, src_fx}, 32'hFFFF);
                end else begin
                    e = q_fx.pop_front();
                    check("fx_out_data", {24'd0, data_fx}, {24'd0, e[10:3]});
                    check("fx_out_src", {29'd0, src_fx}, {29'd0, e[2:0]});
                end
            end
        end
    endtask

    initial begin
        logic [7:0] exp_ack;
        rst = 1'b1; req = 8'hFF; rdy = 1'b1; req_fx = 8'h00; rdy_fx = 1'b1;
        fork
            monitor_rr();
            monitor_fx();
        join_none

        // Reset held for two edges with every requester active.
        tick();
        check("rst_ack_0", {24'd0, ack}, 32'h00);
        tick();
        check("rst_ack_1", {24'd0, ack}, 32'h00);
        check("rst_valid", {31'd0, vld}, 32'd0);
        check("rst_data", {24'd0, data}, 32'h00);
        check("rst_src", {29'd0, src}, 32'd0);

        // Single requester: ack this cycle, word valid next cycle.
        rst = 1'b0; req = 8'h04;
        #1 check("single_ack", {24'd0, ack}, 32'h04);
        q_rr.push_back({8'h04, 3'd2});
        tick();
        req = 8'h00;
        #1 check("single_valid", {31'd0, vld}, 32'd1);
        check("idle_ack", {24'd0, ack}, 32'h00);
        tick();

        // Reset pulse to restart the round-robin pointer at 0.
        req = 8'hFF; rst = 1'b1;
        #1 check("rst_pulse_ack", {24'd0, ack}, 32'h00);
        tick();
        rst = 1'b0;

        // Round-robin sweep 0..7 then wrap to 0.
        for (int i = 0; i < 9; i++) begin
            exp_ack = 8'h01 << (i % 8);
            #1 check("rr_sweep_ack", {24'd0, ack}, {24'd0, exp_ack});
            q_rr.push_back({exp_ack, 3'(i % 8)});
            tick();
        end

        // Backpressure: everything holds, no ack.
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check("bp_ack", {24'd0, ack}, 32'h00);
            check("bp_data", {24'd0, data}, 32'h01);
            check("bp_src", {29'd0, src}, 32'd0);
            tick();
        end

        // Release: next winner is 1, continuing through 6.
        rdy = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            exp_ack = 8'h01 << i;
            #1 check("release_ack", {24'd0, ack}, {24'd0, exp_ack});
            q_rr.push_back({exp_ack, 3'(i)});
            tick();
        end

        // Wrap from 7 back to 0 with requesters 0 and 7.
        req = 8'h81;
        #1 check("wrap_ack7", {24'd0, ack}, 32'h80);
        q_rr.push_back({8'h80, 3'd7});
        tick();
        #1 check("wrap_ack0", {24'd0, ack}, 32'h01);
        q_rr.push_back({8'h01, 3'd0});
        tick();
        req = 8'h00;
        tick();
        tick();

        // Reset while holding a word under backpressure discards it.
        rdy = 1'b0; req = 8'h04;
        #1 check("pre_rst_ack", {24'd0, ack}, 32'h04);
        tick();
        req = 8'h00; rst = 1'b1;
        #1 check("pre_rst_valid", {31'd0, vld}, 32'd1);
        check("in_rst_ack", {24'd0, ack}, 32'h00);
        tick();
        rst = 1'b0;
        #1 check("post_rst_valid", {31'd0, vld}, 32'd0);
        req = 8'h81; rdy = 1'b1;
        #1 check("post_rst_ack0", {24'd0, ack}, 32'h01);
        q_rr.push_back({8'h01, 3'd0});
        tick();
        req = 8'h80;
        #1 check("post_rst_ack7", {24'd0, ack}, 32'h80);
        q_rr.push_back({8'h80, 3'd7});
        tick();
        req = 8'h00;
        tick();
        tick();

        // Fixed priority: requester 5 beats 7 every cycle.
        req_fx = 8'hA0;
        for (int i = 0; i < 5; i++) begin
            #1 check("fx_ack", {24'd0, ack_fx}, 32'h20);
            q_fx.push_back({8'h20, 3'd5});
            tick();
        end
        // Fixed priority ignores the pointer: 0 beats 7 even after grant 5.
        req_fx = 8'h81;
        #1 check("fx_ack0", {24'd0, ack_fx}, 32'h01);
        q_fx.push_back({8'h01, 3'd0});
        tick();
        req_fx = 8'h80;
        #1 check("fx_ack7", {24'd0, ack_fx}, 32'h80);
        q_fx.push_back({8'h80, 3'd7});
        tick();
        req_fx = 8'h00;
        tick();
        tick();
        tick();

        check("rr_queue_drained", q_rr.size(), 32'd0);
        check("fx_queue_drained", q_fx.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
